// File: rtl/cache_pkg.sv
// cache_pkg: shared cache/memory width defaults and burst adaptor state encoding.
package cache_pkg;
    localparam int LINE_W_DEF = 256;
    localparam int BEAT_W_DEF = 64;
    localparam int ADDR_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: turns one cache-line fill/writeback into BEATS memory beats.
module cacheline_burst_adaptor
    import cache_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ca_read,
    input  logic              ca_write,
    input  logic [ADDR_W-1:0] ca_address,
    input  logic [LINE_W-1:0] ca_wdata,
    output logic [LINE_W-1:0] ca_rdata,
    output logic              ca_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int CW         = $clog2(BEATS);

    if (LINE_W % BEAT_W != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_params
        $error("cacheline_burst_adaptor: LINE_W/BEAT_W must be a power of two >= 2");
    end

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d, nxt;
    logic [ADDR_W-1:0] base, base_d, addr_d;
    logic [LINE_W-1:0] line, line_d, rdata_d;
    logic [BEAT_W-1:0] wdata_d;
    logic              resp_d, rd_d, wr_d, last;

    assign nxt  = cnt + 1'b1;
    assign last = cnt == CW'(BEATS - 1);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        base_d  = base;
        line_d  = line;
        rdata_d = ca_rdata;
        resp_d  = 1'b0;
        rd_d    = pmem_read;
        wr_d    = pmem_write;
        addr_d  = pmem_address;
        wdata_d = pmem_wdata;
        case (state)
            IDLE: if (ca_write || ca_read) begin
                state_d = ca_write ? WRITE : READ;
                base_d  = ca_address & ~ADDR_W'(LINE_BYTES - 1);
                line_d  = ca_wdata;
                cnt_d   = '0;
                rd_d    = !ca_write;
                wr_d    = ca_write;
                addr_d  = base_d;
                wdata_d = ca_wdata[BEAT_W-1:0];
            end
            READ, WRITE: if (pmem_resp) begin
                if (state == READ) line_d[int'(cnt)*BEAT_W +: BEAT_W] = pmem_rdata;
                cnt_d   = nxt;
                addr_d  = base + ADDR_W'(nxt) * ADDR_W'(BEAT_BYTES);
                wdata_d = line[int'(nxt)*BEAT_W +: BEAT_W];
                // final beat: drop the strobe, counter wraps only now that the line is done
                if (last) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    resp_d  = 1'b1;
                    rdata_d = (state == READ) ? line_d : ca_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            base         <= '0;
            line         <= '0;
            ca_rdata     <= '0;
            ca_resp      <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            base         <= base_d;
            line         <= line_d;
            ca_rdata     <= rdata_d;
            ca_resp      <= resp_d;
            pmem_read    <= rd_d;
            pmem_write   <= wr_d;
            pmem_address <= addr_d;
            pmem_wdata   <= wdata_d;
        end
    end
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: randomized fills/writebacks against a line-level memory model.
module tb_cacheline_burst_adaptor;
    localparam int LW = 256, BW = 64, AW = 32, NB = 4, BB = 8, LB = 32;
    localparam int WLW = 512, WBW = 32, WNB = 16;

    logic clk = 0, rst = 0;
    always #5 clk = ~clk;

    logic          ca_read = 0, ca_write = 0, ca_resp, pmem_read, pmem_write, pmem_resp = 0;
    logic [AW-1:0] ca_address = 0, pmem_address;
    logic [LW-1:0] ca_wdata = 0, ca_rdata;
    logic [BW-1:0] pmem_wdata, pmem_rdata = 0;

    logic           w_ca_read = 0, w_ca_resp, w_pmem_read, w_pmem_write, w_pmem_resp = 0;
    logic [AW-1:0]  w_ca_address = 0, w_pmem_address;
    logic [WLW-1:0] w_ca_rdata;
    logic [WBW-1:0] w_pmem_wdata, w_pmem_rdata = 0;

    cacheline_burst_adaptor dut (
        .clk(clk), .rst(rst), .ca_read(ca_read), .ca_write(ca_write), .ca_address(ca_address),
        .ca_wdata(ca_wdata), .ca_rdata(ca_rdata), .ca_resp(ca_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    cacheline_burst_adaptor #(.LINE_W(WLW), .BEAT_W(WBW), .ADDR_W(AW)) dut_wide (
        .clk(clk), .rst(rst), .ca_read(w_ca_read), .ca_write(1'b0), .ca_address(w_ca_address),
        .ca_wdata('0), .ca_rdata(w_ca_rdata), .ca_resp(w_ca_resp), .pmem_read(w_pmem_read),
        .pmem_write(w_pmem_write), .pmem_address(w_pmem_address), .pmem_wdata(w_pmem_wdata),
        .pmem_rdata(w_pmem_rdata), .pmem_resp(w_pmem_resp)
    );

    int errors = 0, checks = 0;
    logic [31:0] salt;
    logic [LW-1:0] exp_rdata = '0;
    logic [AW-1:0] log_addr[$];
    logic [BW-1:0] log_wdata[$];
    bit log_rd[$];
    int resp_cnt, first_n, last_n;

    function automatic logic [63:0] mem(input logic [31:0] a);
        return {a ^ salt, ~a};
    endfunction

    function automatic logic [LW-1:0] fill_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < NB; k++) l[k*BW +: BW] = mem(base + 32'(k * BB));
        return l;
    endfunction

    // memory responder: each beat waits 'waits' cycles, then pmem_resp for one cycle
    task automatic run(input int waits, input int target, input int pulse_at);
        int wc = 0, n = 0;
        log_addr.delete(); log_wdata.delete(); log_rd.delete();
        resp_cnt = 0; first_n = -1; last_n = -1;
        while (resp_cnt < target && n < 400) begin
            @(negedge clk); n++;
            if (pulse_at > 0 && n == pulse_at) ca_read = 1;
            else if (pulse_at > 0 && n == pulse_at + 1) ca_read = 0;
            if (pmem_read || pmem_write) begin
                log_addr.push_back(pmem_address); log_wdata.push_back(pmem_wdata); log_rd.push_back(pmem_read);
                if (first_n < 0) first_n = n;
                last_n = n;
            end
            if (ca_resp) begin
                resp_cnt++;
                if (ca_write) ca_write = 0; else ca_read = 0;
            end
            pmem_rdata = mem(pmem_address);
            if ((pmem_read || pmem_write) && wc == waits) begin pmem_resp = 1; wc = 0; end
            else begin pmem_resp = 0; if (pmem_read || pmem_write) wc++; end
        end
        pmem_resp = 0;
        checks++;
        if (resp_cnt != target) begin errors++; $display("FAIL run_resp_count: got %0d want %0d", resp_cnt, target); end
    endtask

    task automatic test_reset();
        logic [31:0] base;
        repeat (2) @(negedge clk);
        checks++;
        if ({ca_rdata, ca_resp, pmem_read, pmem_write, pmem_address, pmem_wdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: got rdata=%h strobes=%b%b%b not all zero", ca_rdata, ca_resp, pmem_read, pmem_write);
        end
        ca_address = $urandom; base = ca_address & ~32'(LB - 1);
        ca_read = 1; rst = 1;
        run(0, 1, 0);
        checks++;
        if (first_n !== 1) begin errors++; $display("FAIL reset_first_accept: strobe in cycle %0d want 1", first_n); end
        exp_rdata = fill_line(base);
        checks++;
        if (ca_rdata !== exp_rdata) begin errors++; $display("FAIL reset_first_fill: got %h want %h", ca_rdata, exp_rdata); end
    endtask

    task automatic test_fill_zero_wait();
        logic [31:0] want[4] = '{32'h1234_5660, 32'h1234_5668, 32'h1234_5670, 32'h1234_5678};
        ca_address = 32'h1234_5678; ca_read = 1;
        run(0, 1, 0);
        checks++;
        if (log_addr.size() != 4 || last_n - first_n != 3) begin
            errors++; $display("FAIL zw_beats: got %0d strobes over %0d cycles want 4 over 4", log_addr.size(), last_n - first_n + 1);
        end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== want[i] || log_rd[i] !== 1'b1) begin errors++; $display("FAIL zw_addr%0d: got %h rd=%b want %h rd=1", i, log_addr[i], log_rd[i], want[i]); end
        end
        exp_rdata = {mem(want[3]), mem(want[2]), mem(want[1]), mem(want[0])};
        checks++;
        if (ca_rdata !== exp_rdata) begin errors++; $display("FAIL zw_rdata: got %h want %h", ca_rdata, exp_rdata); end
        @(negedge clk);
        checks++;
        if (ca_resp !== 1'b0 || pmem_read !== 1'b0) begin errors++; $display("FAIL zw_resp_pulse: resp=%b rd=%b want 0 0", ca_resp, pmem_read); end
    endtask

    task automatic test_fill_random();
        for (int t = 0; t < 3; t++) begin
            int w = int'($urandom_range(0, 3));
            logic [31:0] base;
            ca_address = $urandom; base = ca_address & ~32'(LB - 1); ca_read = 1;
            run(w, 1, 0);
            checks++;
            if (log_addr.size() != NB * (w + 1)) begin errors++; $display("FAIL fill%0d_len: got %0d want %0d", t, log_addr.size(), NB * (w + 1)); end
            for (int i = 0; i < log_addr.size(); i++) begin
                logic [31:0] ea = base + 32'((i / (w + 1)) * BB);
                checks++;
                if (log_addr[i] !== ea) begin errors++; $display("FAIL fill%0d_addr%0d: got %h want %h", t, i, log_addr[i], ea); end
            end
            exp_rdata = fill_line(base);
            checks++;
            if (ca_rdata !== exp_rdata) begin errors++; $display("FAIL fill%0d_rdata: got %h want %h", t, ca_rdata, exp_rdata); end
        end
    endtask

    task automatic test_write();
        logic [31:0] base;
        for (int k = 0; k < LW / 32; k++) ca_wdata[k*32 +: 32] = $urandom;
        ca_address = $urandom; base = ca_address & ~32'(LB - 1); ca_write = 1;
        run(2, 1, 0);
        checks++;
        if (log_addr.size() != 12) begin errors++; $display("FAIL wr_len: got %0d want 12", log_addr.size()); end
        for (int i = 0; i < log_addr.size(); i++) begin
            logic [BW-1:0] ed = ca_wdata[(i / 3)*BW +: BW];
            logic [31:0] ea = base + 32'((i / 3) * BB);
            checks++;
            if (log_wdata[i] !== ed || log_addr[i] !== ea || log_rd[i] !== 1'b0) begin
                errors++; $display("FAIL wr_beat%0d: got %h@%h rd=%b want %h@%h rd=0", i, log_wdata[i], log_addr[i], log_rd[i], ed, ea);
            end
        end
        checks++;
        if (ca_rdata !== exp_rdata) begin errors++; $display("FAIL wr_rdata_kept: got %h want %h", ca_rdata, exp_rdata); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] base;
        for (int k = 0; k < LW / 32; k++) ca_wdata[k*32 +: 32] = $urandom;
        ca_address = $urandom; base = ca_address & ~32'(LB - 1);
        ca_read = 1; ca_write = 1;
        run(1, 2, 0);
        checks++;
        if (log_rd.size() != 16) begin errors++; $display("FAIL both_len: got %0d want 16", log_rd.size()); end
        for (int i = 0; i < log_rd.size(); i++) begin
            checks++;
            if (log_rd[i] !== (i >= 8)) begin errors++; $display("FAIL both_order%0d: got rd=%b want %b", i, log_rd[i], i >= 8); end
        end
        exp_rdata = fill_line(base);
        checks++;
        if (ca_rdata !== exp_rdata) begin errors++; $display("FAIL both_rdata: got %h want %h", ca_rdata, exp_rdata); end
    endtask

    task automatic test_mid_burst_request();
        ca_address = $urandom; ca_write = 1;
        run(1, 1, 4);
        checks++;
        if (log_rd.size() != 8) begin errors++; $display("FAIL midreq_len: got %0d want 8", log_rd.size()); end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || ca_resp !== 1'b0) begin
                errors++; $display("FAIL midreq_idle: got rd=%b wr=%b resp=%b want 0", pmem_read, pmem_write, ca_resp);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] base;
        ca_address = $urandom; ca_read = 1; pmem_resp = 1;
        repeat (4) @(negedge clk);
        rst = 0; ca_read = 0;
        #1;
        checks++;
        if ({ca_rdata, ca_resp, pmem_read, pmem_write, pmem_address, pmem_wdata} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got rdata=%h rd=%b resp=%b want zero", ca_rdata, pmem_read, ca_resp);
        end
        exp_rdata = '0;
        @(negedge clk); rst = 1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (pmem_read !== 1'b0 || ca_resp !== 1'b0 || ca_rdata !== '0) begin
                errors++; $display("FAIL rstmid_stray: got rd=%b resp=%b rdata=%h want 0", pmem_read, ca_resp, ca_rdata);
            end
        end
        pmem_resp = 0;
        ca_address = $urandom; base = ca_address & ~32'(LB - 1); ca_read = 1;
        run(1, 1, 0);
        exp_rdata = fill_line(base);
        checks++;
        if (ca_rdata !== exp_rdata) begin errors++; $display("FAIL rstmid_refill: got %h want %h", ca_rdata, exp_rdata); end
    endtask

    task automatic test_wide();
        logic [31:0] base, addrs[$];
        logic [63:0] m;
        logic [WLW-1:0] exp;
        int n = 0, resps = 0;
        w_ca_address = $urandom; base = w_ca_address & ~32'(WLW / 8 - 1);
        w_ca_read = 1; w_pmem_resp = 1;
        while (resps == 0 && n < 60) begin
            @(negedge clk); n++;
            if (w_pmem_read) addrs.push_back(w_pmem_address);
            if (w_ca_resp) begin resps++; w_ca_read = 0; end
            m = mem(w_pmem_address); w_pmem_rdata = m[31:0];
        end
        w_pmem_resp = 0;
        checks++;
        if (addrs.size() != WNB || resps != 1) begin errors++; $display("FAIL wide_len: got %0d beats %0d resp want 16 1", addrs.size(), resps); end
        for (int k = 0; k < WNB; k++) begin
            m = mem(base + 32'(4 * k)); exp[k*WBW +: WBW] = m[31:0];
            if (k < addrs.size()) begin
                checks++;
                if (addrs[k] !== base + 32'(4 * k)) begin errors++; $display("FAIL wide_addr%0d: got %h want %h", k, addrs[k], base + 32'(4 * k)); end
            end
        end
        checks++;
        if (w_ca_rdata !== exp) begin errors++; $display("FAIL wide_rdata: got %h want %h", w_ca_rdata, exp); end
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_fill_zero_wait();
        test_fill_random();
        test_write();
        test_simultaneous();
        test_mid_burst_request();
        test_reset_mid_burst();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cacheline_burst_adaptor.md
CACHELINE_BURST_ADAPTOR -- requirements
Module: cacheline_burst_adaptor

Interface
REQ-001 Parameters SHALL be (name, default, meaning): LINE_W, 256, cache-line width in bits.
REQ-002 BEAT_W, 64, memory data-beat width in bits.
REQ-003 ADDR_W, 32, byte-address width.
REQ-004 Derived constants SHALL be BEATS = LINE_W/BEAT_W, BEAT_BYTES = BEAT_W/8 and LINE_BYTES = LINE_W/8.
REQ-005 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock.
REQ-006 rst, in, 1, reset; asynchronous, active-low.
REQ-007 ca_read, in, 1, cache line-fill request.
REQ-008 ca_write, in, 1, cache line-writeback request.
REQ-009 ca_address, in, ADDR_W, cache byte address.
REQ-010 ca_wdata, in, LINE_W, writeback line; beat 0 is bits [BEAT_W-1:0].
REQ-011 ca_rdata, out, LINE_W, filled line.
REQ-012 ca_resp, out, 1, one-cycle completion pulse.
REQ-013 pmem_read, out, 1, beat read strobe.
REQ-014 pmem_write, out, 1, beat write strobe.
REQ-015 pmem_address, out, ADDR_W, current beat byte address.
REQ-016 pmem_wdata, out, BEAT_W, current write beat.
REQ-017 pmem_rdata, in, BEAT_W, returned read beat.
REQ-018 pmem_resp, in, 1, beat accepted or returned.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 The FSM SHALL have states IDLE, READ, WRITE and DONE.
REQ-021 In IDLE, ca_write SHALL take priority over ca_read: a simultaneous request services the write, and the read is re-sampled after DONE.
REQ-022 On acceptance, base = ca_address with the low log2(LINE_BYTES) bits cleared SHALL be latched, ca_wdata SHALL be latched, and the beat counter SHALL be cleared.
REQ-023 From acceptance in cycle N, the pmem strobe SHALL assert in cycle N+1.
REQ-024 pmem_address SHALL equal base + cnt*BEAT_BYTES.
REQ-025 pmem_read or pmem_write SHALL be held high and address/wdata held stable until pmem_resp is sampled high.
REQ-026 READ: each sampled pmem_resp SHALL store pmem_rdata into line slice cnt and increment cnt.
REQ-027 WRITE: pmem_wdata SHALL be latched-line slice cnt; each sampled pmem_resp SHALL increment cnt.
REQ-028 A pmem_resp sampled with cnt = BEATS-1 SHALL move the FSM to DONE and drop the strobe in the next cycle, with no extra beat issued.
REQ-029 DONE SHALL assert ca_resp for exactly one cycle, then return to IDLE.
REQ-030 ca_rdata SHALL update only on READ completion and hold its value until the next fill completes; writes SHALL NOT alter it.
REQ-031 Requests arriving while not in IDLE SHALL be ignored; the cache holds its request until ca_resp and drops it in the following cycle.
REQ-032 pmem_resp sampled in IDLE or DONE SHALL be ignored.
REQ-033 Zero-wait memory (pmem_resp high every cycle) SHALL complete BEATS beats in BEATS consecutive cycles.
REQ-034 cnt SHALL be $clog2(BEATS) bits wide and SHALL NOT wrap within a transaction.

Reset
REQ-035 Asserting rst low SHALL immediately force IDLE, cnt=0 and all outputs to 0, including ca_rdata.
REQ-036 Reset mid-burst SHALL abort the transaction with no ca_resp.
REQ-037 After rst rises, the first request SHALL be accepted on the first clk edge.

Structure
REQ-038 The state enum and default LINE_W/BEAT_W/ADDR_W constants SHALL live in the shared package cache_pkg.
REQ-039 The block SHALL be a single module with no sub-modules; the beat counter and line buffer are inline.
REQ-040 Elaboration SHALL fail unless LINE_W % BEAT_W == 0, BEATS is a power of two, and BEATS >= 2.

Verification
REQ-041 Fill, zero-wait, defaults, ca_address=0x1234_5678 -> pmem_address 0x1234_5660/68/70/78 across four consecutive cycles; rdata beats A0..A3 assembled as {A3,A2,A1,A0}; one ca_resp pulse.
REQ-042 Writeback with two wait cycles per beat, ca_wdata = {D3,D2,D1,D0} -> each pmem_wdata Dk held 3 cycles; 12 strobe cycles; ca_resp once; ca_rdata unchanged.
REQ-043 ca_read and ca_write high together -> write burst first, then ca_resp, then read burst with a second ca_resp.
REQ-044 rst low after beat 2 of a fill -> all outputs 0 within the same cycle; a stray pmem_resp afterwards is ignored; the next fill completes correctly.
REQ-045 New ca_read pulsed mid-burst -> ignored; exactly BEATS strobes issued.
REQ-046 LINE_W=512, BEAT_W=32 -> 16 beats, address step 4, cnt wraps only after completion.
